clock_divider_mc: RTL

//  Multi-channel programmable clock divider; successor to the single-channel 8-bit divider.
//  NUM_CH independent channels, each dividing clk by a runtime divisor N, with registered glitch-free outputs.

---
 rtl/clock_divider_pkg.sv | 12 +
 rtl/clock_divider_ch.sv | 63 ++++++
 rtl/clock_divider_mc.sv | 46 ++++
 3 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    localparam int DIV_W_DEF     = 8;
    localparam int RESET_DIV_DEF = 2;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: shadow/active divisor, phase counter and registered outputs.
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] eff;
    logic [DIV_W-1:0] half;
    logic             enabled;
    logic             boundary;

    always_comb begin
        enabled  = (active != '0);
        eff      = (active == DIV_W'(1)) ? DIV_W'(2) : active;
        half     = eff >> 1;
        // A disabled channel sits permanently at a period boundary.
        boundary = sync || !enabled || (cnt == eff - DIV_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= DIV_W'(RESET_DIV);
            active  <= DIV_W'(RESET_DIV);
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else if (ena) begin
            clk_out <= enabled && (cnt < half);
            tick    <= enabled && (cnt == '0);
            if (boundary) begin
                cnt <= '0;
                if (pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            // A write in a boundary cycle only arms the shadow; it applies next boundary.
            if (wr_en) begin
                shadow  <= wr_div;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider: decodes config writes into per-channel strobes.
module clock_divider_mc
    import clock_divider_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  DIV_W     = DIV_W_DEF,
    parameter int  RESET_DIV = RESET_DIV_DEF,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] wr_en;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            // Selects beyond NUM_CH match no channel and are dropped.
            assign wr_en[i] = cfg_we && (cfg_ch == CH_W'(i));

            clock_divider_ch #(
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .ena     (ena),
                .wr_en   (wr_en[i]),
                .wr_div  (cfg_div),
                .sync    (sync),
                .clk_out (clk_out[i]),
                .tick    (tick[i]),
                .pending (pending[i])
            );
        end
    endgenerate

endmodule
